regfile_sb: RTL

//   Parametrised multi-read-port register file with a per-register pending-write scoreboard.
//   It is the next-generation integer register file for the pipelined RISC-V core.

---
 rtl/regfile_sb_if.sv | 28 ++
 rtl/regfile_sb.sv | 87 ++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Bus bundle for the scoreboarded register file: write/writeback, reserve and read ports.
// The core side drives it through the master modport; the register file sits on the slave.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRD   = 2
);
  logic                we3;
  logic [AW-1:0]       wa3;
  logic [XLEN-1:0]     wd3;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      busy;
  logic [DEPTH-1:0]    pend_vec;

  modport master (
    output we3, wa3, wd3, rsv_en, rsv_addr, ra,
    input  rd, busy, pend_vec
  );

  modport slave (
    input  we3, wa3, wd3, rsv_en, rsv_addr, ra,
    output rd, busy, pend_vec
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with a per-register pending-write scoreboard.
// Issue reserves a destination, writeback writes and releases it; reads return data plus busy.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);

  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [XLEN-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             wr_ok;
  logic             rsv_ok;

  // An address is usable only if it names an existing, writable register.
  // Decoding against each index keeps every compare AW bits wide for any DEPTH.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == AW'(i) && !(ZERO_REG && i == 0)) ok = 1'b1;
    end
    return ok;
  endfunction

  assign wr_ok  = bus.we3 && addr_ok(bus.wa3);
  assign rsv_ok = bus.rsv_en && addr_ok(bus.rsv_addr);

  // NOTE: every combinational output starts from a default, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && bus.wa3 == AW'(i)) begin
        regs_d[i] = bus.wd3;
        pend_d[i] = 1'b0;
      end
    end
    // Applied after the release so a same-register reserve wins: the new producer
    // supersedes the one retiring.
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv_ok && bus.rsv_addr == AW'(i)) pend_d[i] = 1'b1;
    end
  end

  // NOTE: the data array is reset as well, because reset must clear every
  // register asynchronously; state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign bus.pend_vec = pend_q;

  // Reads are combinational; rst_n gating keeps a bypassed write off the ports in reset.
  always_comb begin
    logic [AW-1:0] a;
    bus.rd   = '0;
    bus.busy = '0;
    for (int p = 0; p < NRD; p++) begin
      a = bus.ra[p*AW +: AW];
      if (rst_n && addr_ok(a)) begin
        bus.rd[p*XLEN +: XLEN] = regs_q[a];
        bus.busy[p]            = pend_q[a];
        if (BYPASS && wr_ok && bus.wa3 == a) begin
          bus.rd[p*XLEN +: XLEN] = bus.wd3;
          bus.busy[p]            = 1'b0;
        end
      end
    end
  end

endmodule
